// File: rtl/hex_scan_display_driver.sv
// Eight-digit multiplexed 7-segment driver for a 32-bit debug word, with
// leading-zero blanking and a timed blink of the nibbles changed by the last load.
module hex_scan_display_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_DIV    = 12500000,
  parameter int BLINK_PHASES = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] HexDisplay32Bits,
  input  logic        Load,
  input  logic        Blank_Leading_Zeros,
  input  logic        Blink_Enable,
  output logic [6:0]  SEG,
  output logic [7:0]  DIGIT_EN,
  output logic [31:0] Display_Value,
  output logic        Blink_Busy
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PH_W    = (BLINK_PHASES > 1) ? $clog2(BLINK_PHASES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_OFF, ST_ON} blink_state_t;

  logic [31:0]        r_value;
  logic [7:0]         r_mask;
  logic [2:0]         r_scan_idx;
  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [BLINK_W-1:0] r_timer;
  logic [PH_W-1:0]    r_phase;
  blink_state_t       r_state;
  logic [6:0]         r_seg;
  logic [7:0]         r_digit_en;

  blink_state_t       w_state_nxt;
  logic [7:0]         w_mask_nxt;
  logic [BLINK_W-1:0] w_timer_nxt;
  logic [PH_W-1:0]    w_phase_nxt;
  logic [7:0]         w_load_mask;
  logic [4:0]         w_base;
  logic [3:0]         w_nibble;
  logic               w_upper_zero;
  logic               w_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_timer_nxt = r_timer;
    w_phase_nxt = r_phase;
    for (int i = 0; i < 8; i++)
      w_load_mask[i] = HexDisplay32Bits[i*4 +: 4] != r_value[i*4 +: 4];

    if (Load) begin
      w_timer_nxt = '0;
      w_phase_nxt = '0;
      if (Blink_Enable && (w_load_mask != 8'h00)) begin
        w_state_nxt = ST_OFF;
        w_mask_nxt  = w_load_mask;
      end else begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
      end
    end else if (!Blink_Enable) begin
      w_state_nxt = ST_IDLE;
      w_mask_nxt  = '0;
      w_timer_nxt = '0;
      w_phase_nxt = '0;
    end else if (r_state != ST_IDLE) begin
      if (r_timer == BLINK_W'(BLINK_DIV - 1)) begin
        w_timer_nxt = '0;
        if (r_phase == PH_W'(BLINK_PHASES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
          w_state_nxt = (r_state == ST_OFF) ? ST_ON : ST_OFF;
        end
      end else begin
        w_timer_nxt = r_timer + 1'b1;
      end
    end
  end

  // Digit i is a leading zero when it and every higher nibble are zero.
  always_comb begin
    w_base       = {r_scan_idx, 2'b00};
    w_nibble     = r_value[w_base +: 4];
    w_upper_zero = (r_value >> w_base) == 32'h0;
    w_blank      = ((r_scan_idx != 3'd0) && Blank_Leading_Zeros && w_upper_zero) ||
                   ((r_state == ST_OFF) && r_mask[r_scan_idx]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_value    <= '0;
      r_mask     <= '0;
      r_scan_idx <= '0;
      r_scan_cnt <= '0;
      r_timer    <= '0;
      r_phase    <= '0;
      r_state    <= ST_IDLE;
      r_seg      <= 7'h7F;
      r_digit_en <= 8'hFF;
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_scan_idx <= r_scan_idx + 1'b1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
      if (Load) r_value <= HexDisplay32Bits;
      r_mask     <= w_mask_nxt;
      r_timer    <= w_timer_nxt;
      r_phase    <= w_phase_nxt;
      r_state    <= w_state_nxt;
      r_digit_en <= ~(8'h01 << r_scan_idx);
      r_seg      <= w_blank ? 7'h7F : hex_to_seg(w_nibble);
    end
  end

  assign SEG           = r_seg;
  assign DIGIT_EN      = r_digit_en;
  assign Display_Value = r_value;
  assign Blink_Busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hex_scan_display_driver.sv
// Self-checking bench: directed scenarios plus random loads, all compared each
// cycle against a time-based model of scan position and blink phase.
module tb_hex_scan_display_driver;

  localparam int SD = 4;
  localparam int BD = 8;
  localparam int BP = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] HexDisplay32Bits = '0;
  logic        Load = 1'b0;
  logic        Blank_Leading_Zeros = 1'b0;
  logic        Blink_Enable = 1'b0;
  logic [6:0]  SEG;
  logic [7:0]  DIGIT_EN;
  logic [31:0] Display_Value;
  logic        Blink_Busy;

  hex_scan_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .BLINK_PHASES(BP)) dut (
    .Clock(Clock), .Reset(Reset), .HexDisplay32Bits(HexDisplay32Bits), .Load(Load),
    .Blank_Leading_Zeros(Blank_Leading_Zeros), .Blink_Enable(Blink_Enable),
    .SEG(SEG), .DIGIT_EN(DIGIT_EN), .Display_Value(Display_Value), .Blink_Busy(Blink_Busy)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Model: edges since reset, latched word, and the edge at which blinking began.
  logic [31:0] m_value = '0;
  logic [7:0]  m_mask  = '0;
  bit          m_blink = 1'b0;
  int          m_n     = 0;
  int          m_start = 0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // -1 when idle, otherwise the number of whole blink phases elapsed.
  function automatic int blink_phase();
    int p;
    if (!m_blink) return -1;
    p = (m_n - m_start) / BD;
    return (p >= BP) ? -1 : p;
  endfunction

  task automatic step(input logic rst, input logic ld, input logic [31:0] d,
                      input logic blank, input logic en);
    logic [6:0] e_seg;
    logic [7:0] e_dig;
    logic [7:0] nm;
    int         idx, p;
    bit         lead_zero, off;
    Reset = rst; Load = ld; HexDisplay32Bits = d;
    Blank_Leading_Zeros = blank; Blink_Enable = en;
    if (rst) begin
      e_seg = 7'h7F;
      e_dig = 8'hFF;
      m_n = 0; m_value = '0; m_mask = '0; m_blink = 1'b0;
    end else begin
      idx = (m_n / SD) % 8;
      lead_zero = (idx > 0);
      for (int k = idx; k < 8; k++)
        if (((m_value / (32'd1 << (4 * k))) % 16) != 0) lead_zero = 1'b0;
      p = blink_phase();
      off = (p >= 0) && (p % 2 == 0);
      e_dig = 8'hFF;
      e_dig[idx] = 1'b0;
      e_seg = ((blank && lead_zero) || (off && m_mask[idx])) ? 7'h7F
              : seg_tab[(m_value / (32'd1 << (4 * idx))) % 16];
      m_n++;
      if (ld) begin
        for (int k = 0; k < 8; k++)
          nm[k] = ((d / (32'd1 << (4 * k))) % 16) != ((m_value / (32'd1 << (4 * k))) % 16);
        m_value = d;
        if (en && nm != 8'h00) begin
          m_blink = 1'b1; m_start = m_n; m_mask = nm;
        end else begin
          m_blink = 1'b0;
        end
      end else if (!en) begin
        m_blink = 1'b0;
      end
    end
    @(posedge Clock);
    #1;
    check("seg", SEG, e_seg);
    check("digit_en", DIGIT_EN, e_dig);
    check("value", Display_Value, m_value);
    check("busy", Blink_Busy, blink_phase() >= 0);
  endtask

  task automatic idle_steps(input int n, input logic blank, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, blank, en);
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] d;
    logic blank, en;

    // 1: reset, run mid-scan, reset held 3 cycles, release
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle_steps(6, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_seg", SEG, 7'h7F);
    check("rst_digit", DIGIT_EN, 8'hFF);
    check("rst_busy", Blink_Busy, 1'b0);
    idle_steps(1, 1'b0, 1'b0);
    check("first_digit", DIGIT_EN, 8'hFE);

    // 2: full scan of a mixed word, including index wrap
    step(1'b0, 1'b1, 32'h0123_ABCD, 1'b0, 1'b0);
    idle_steps(40, 1'b0, 1'b0);

    // 3: leading-zero blanking
    step(1'b0, 1'b1, 32'h0000_00A0, 1'b1, 1'b0);
    idle_steps(34, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    idle_steps(34, 1'b1, 1'b0);

    // 4: single-nibble change blinks for BP phases of BD cycles
    step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    busy_cnt = 0;
    step(1'b0, 1'b1, 32'h1111_1191, 1'b0, 1'b1);
    if (Blink_Busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 39; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      if (Blink_Busy === 1'b1) busy_cnt++;
    end
    check("busy_len", busy_cnt, 32);

    // 5: restart mid-blink, then identical reload ends it
    step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1);
    idle_steps(13, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h2211_1111, 1'b0, 1'b1);
    idle_steps(9, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h2211_1111, 1'b0, 1'b1);
    check("same_word_idle", Blink_Busy, 1'b0);
    idle_steps(4, 1'b0, 1'b1);

    // 6: enable dropped mid-OFF, then load colliding with reset
    step(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1);
    idle_steps(3, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("drop_en_idle", Blink_Busy, 1'b0);
    idle_steps(4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("rst_over_load", Display_Value, 32'h0);

    // Random traffic
    blank = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) blank = ~blank;
      if ($urandom_range(31) == 0) en = ~en;
      d = '0;
      for (int k = 0; k < 8; k++)
        if ($urandom_range(1)) d[k*4 +: 4] = 4'($urandom_range(15));
      if ($urandom_range(3) == 0) begin
        d = m_value;
        d[$urandom_range(7)*4 +: 4] = 4'($urandom_range(15));
      end
      step($urandom_range(299) == 0, $urandom_range(11) == 0, d, blank, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
